// File: rtl/sd_card_fifo_writer.sv
// sd_card_fifo_writer
// Takes one sector's byte stream from the SD receive datapath, packs the bytes
// four at a time into 32-bit words and pushes them into the prefetch FIFO
// write port. Start, done and abort control lets the command sequencer track
// sector completion. Single clock domain (wr_clk), synchronous reset.

module sd_card_fifo_writer #(
    parameter int c_SECTOR_BYTES = 512,
    parameter bit c_BIG_ENDIAN   = 1'b0,
    parameter int c_CNT_WIDTH    = 10
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    input  logic                   sec_start,
    input  logic                   sec_abort,
    input  logic [7:0]             sec_byte,
    input  logic                   sec_byte_vld,
    output logic                   sec_byte_rdy,
    output logic                   sec_busy,
    output logic                   sec_done,
    output logic [c_CNT_WIDTH-1:0] byte_cnt,
    output logic [31:0]            wr_data,
    output logic                   wr_en,
    input  logic                   wr_vld
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Index of the final byte of a sector, in byte counter width.
    localparam logic [c_CNT_WIDTH-1:0] c_LAST_IDX = c_CNT_WIDTH'(c_SECTOR_BYTES - 1);

    state_t                   state_q, state_d;
    logic [1:0]               lane_cnt_q, lane_cnt_d;
    logic [2:0][7:0]          pack_q, pack_d;
    logic [c_CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic                     wr_en_q, wr_en_d;
    logic [31:0]              wr_data_q, wr_data_d;
    logic                     sec_done_q, sec_done_d;

    logic                     byte_rdy;
    logic                     byte_acc;
    logic                     wr_fire;
    logic [3:0][7:0]          lane_bytes;
    logic [31:0]              word_full;

    // Handshake terms. Only the lane-3 byte can stall: it is the one that
    // would overwrite a still-pending output word.
    assign byte_rdy = (state_q == ST_RECV) &&
                      ((lane_cnt_q != 2'd3) || !wr_en_q || wr_vld);
    assign byte_acc = sec_byte_vld && byte_rdy;
    assign wr_fire  = wr_en_q && wr_vld;

    // The word being completed: three held lanes plus the incoming lane-3 byte.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane_src
            assign lane_bytes[gi] = pack_q[gi];
        end
    endgenerate
    assign lane_bytes[3] = sec_byte;

    // Byte-lane placement inside the FIFO word depends on the endianness choice.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word_map
            if (c_BIG_ENDIAN) begin : g_big
                assign word_full[31 - 8*gi -: 8] = lane_bytes[gi];
            end else begin : g_little
                assign word_full[8*gi +: 8] = lane_bytes[gi];
            end
        end
    endgenerate

    // Next-state logic: sector FSM, byte packing, output word register.
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        wr_en_d    = wr_en_q;
        wr_data_d  = wr_data_q;
        sec_done_d = 1'b0;

        // A completed write empties the output register; a word loaded in the
        // same cycle below takes precedence.
        if (wr_fire) begin
            wr_en_d   = 1'b0;
            wr_data_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sec_start) begin
                    state_d    = ST_RECV;
                    byte_cnt_d = '0;
                    lane_cnt_d = 2'd0;
                    pack_d     = '0;
                end
            end

            ST_RECV: begin
                if (byte_acc) begin
                    for (int i = 0; i < 3; i++) begin
                        if (lane_cnt_q == 2'(i)) begin
                            pack_d[i] = sec_byte;
                        end
                    end
                    lane_cnt_d = lane_cnt_q + 2'd1;
                    byte_cnt_d = byte_cnt_q + c_CNT_WIDTH'(1);
                    if (lane_cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word_full;
                    end
                    if (byte_cnt_q == c_LAST_IDX) begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                if (wr_fire) begin
                    state_d    = ST_IDLE;
                    sec_done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything except reset. byte_cnt is left as it was
        // so the sequencer can see how far the sector got.
        if (sec_abort) begin
            state_d    = ST_IDLE;
            lane_cnt_d = 2'd0;
            pack_d     = '0;
            byte_cnt_d = byte_cnt_q;
            wr_en_d    = 1'b0;
            wr_data_d  = '0;
            sec_done_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q    <= ST_IDLE;
            lane_cnt_q <= 2'd0;
            pack_q     <= '0;
            byte_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            sec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            sec_done_q <= sec_done_d;
        end
    end

    assign sec_byte_rdy = byte_rdy;
    assign sec_busy     = (state_q != ST_IDLE);
    assign sec_done     = sec_done_q;
    assign byte_cnt     = byte_cnt_q;
    assign wr_data      = wr_data_q;
    assign wr_en        = wr_en_q;

endmodule

// File: tb/tb_sd_card_fifo_writer.sv
// Testbench for sd_card_fifo_writer: scoreboard of expected FIFO words,
// pushed when a sector's byte stream is planned and popped on each FIFO write.

module tb_sd_card_fifo_writer;

    logic        clk = 1'b0;
    logic        wr_rst = 1'b1;
    logic        sec_start = 1'b0;
    logic        sec_abort = 1'b0;
    logic [7:0]  sec_byte = '0;
    logic        sec_byte_vld = 1'b0;
    logic        sec_byte_rdy;
    logic        sec_busy;
    logic        sec_done;
    logic [9:0]  byte_cnt;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_vld = 1'b1;

    // Small big-endian instance with a 4-byte sector.
    logic        be_start = 1'b0;
    logic [7:0]  be_byte = '0;
    logic        be_vld = 1'b0;
    logic        be_rdy;
    logic        be_busy;
    logic        be_done;
    logic [2:0]  be_cnt;
    logic [31:0] be_wr_data;
    logic        be_wr_en;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle_cnt = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          write_cnt = 0;
    bit          rnd_wr = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sd_card_fifo_writer #(
        .c_SECTOR_BYTES(512),
        .c_BIG_ENDIAN  (1'b0),
        .c_CNT_WIDTH   (10)
    ) dut (
        .wr_clk      (clk),
        .wr_rst      (wr_rst),
        .sec_start   (sec_start),
        .sec_abort   (sec_abort),
        .sec_byte    (sec_byte),
        .sec_byte_vld(sec_byte_vld),
        .sec_byte_rdy(sec_byte_rdy),
        .sec_busy    (sec_busy),
        .sec_done    (sec_done),
        .byte_cnt    (byte_cnt),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_vld      (wr_vld)
    );

    sd_card_fifo_writer #(
        .c_SECTOR_BYTES(4),
        .c_BIG_ENDIAN  (1'b1),
        .c_CNT_WIDTH   (3)
    ) dut_be (
        .wr_clk      (clk),
        .wr_rst      (wr_rst),
        .sec_start   (be_start),
        .sec_abort   (1'b0),
        .sec_byte    (be_byte),
        .sec_byte_vld(be_vld),
        .sec_byte_rdy(be_rdy),
        .sec_busy    (be_busy),
        .sec_done    (be_done),
        .byte_cnt    (be_cnt),
        .wr_data     (be_wr_data),
        .wr_en       (be_wr_en),
        .wr_vld      (1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'(i) ^ 8'(seed * 91);
    endfunction

    // Little-endian reference packing of a planned sector.
    task automatic push_sector(input int seed);
        for (int k = 0; k < 128; k++) begin
            exp_q.push_back({pat(seed, 4*k+3), pat(seed, 4*k+2),
                             pat(seed, 4*k+1), pat(seed, 4*k)});
        end
    endtask

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Monitor: a write is observed at the negedge before the edge that takes it.
    always @(negedge clk) begin
        if (!wr_rst && wr_en && wr_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_qsize", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("wr_data", wr_data, exp_q.pop_front());
            end
            write_cnt++;
            $display("write %0d data=%h", write_cnt, wr_data);
        end
        if (!wr_rst && sec_done) begin
            done_cnt++;
            done_cyc = cycle_cnt;
            chk("busy_at_done", 32'(sec_busy), 32'd0);
            $display("sector done #%0d at cycle %0d", done_cnt, cycle_cnt);
        end
    end

    // Random FIFO backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_wr) wr_vld = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard;
        if (rnd) begin
            while ($urandom_range(0, 3) == 0) begin
                sec_byte_vld = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        sec_byte = b;
        sec_byte_vld = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (sec_byte_rdy) break;
            guard++;
            if (guard > 2000) begin
                chk("byte_accept_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        sec_byte_vld = 1'b0;
    endtask

    task automatic send_range(input int seed, input int lo, input int hi, input bit rnd);
        for (int i = lo; i <= hi; i++) send_byte(pat(seed, i), rnd);
    endtask

    task automatic start_sector();
        @(posedge clk);
        #1;
        sec_start = 1'b1;
        @(negedge clk);
        start_cyc = cycle_cnt;
        @(posedge clk);
        #1;
        sec_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        chk("done_count", 32'(done_cnt), 32'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          w0;
        int          d0;
        logic [31:0] word0;
        logic [7:0]  be_vals[4];
        be_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(sec_byte_rdy), 32'd0);
        chk("rst_busy", 32'(sec_busy), 32'd0);
        chk("rst_done", 32'(sec_done), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        wr_rst = 1'b0;

        // Full sector, FIFO never full: 128 writes, 514 cycles start->done
        push_sector(0);
        w0 = write_cnt;
        start_sector();
        chk("start_busy", 32'(sec_busy), 32'd1);
        chk("start_rdy", 32'(sec_byte_rdy), 32'd1);
        send_range(0, 0, 511, 1'b0);
        wait_done(1);
        chk("sector_cycles", 32'(done_cyc - start_cyc), 32'd514);
        chk("sector_writes", 32'(write_cnt - w0), 32'd128);
        repeat (5) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt), 32'd1);

        // Big-endian packing
        be_start = 1'b1;
        @(posedge clk);
        #1;
        be_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            be_byte = be_vals[i];
            be_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        be_vld = 1'b0;
        chk("be_wr_en", 32'(be_wr_en), 32'd1);
        chk("be_wr_data", be_wr_data, 32'h11223344);
        @(posedge clk);
        #1;
        chk("be_done", 32'(be_done), 32'd1);

        // Backpressure: lane-3 byte stalls while a word is pending
        push_sector(1);
        word0 = exp_q[0];
        wr_vld = 1'b0;
        start_sector();
        send_range(1, 0, 6, 1'b0);
        sec_byte = pat(1, 7);
        sec_byte_vld = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_rdy", 32'(sec_byte_rdy), 32'd0);
            chk("stall_wr_en", 32'(wr_en), 32'd1);
            chk("stall_wr_data", wr_data, word0);
        end
        @(posedge clk);
        #1;
        wr_vld = 1'b1;
        send_byte(pat(1, 7), 1'b0);
        send_range(1, 8, 511, 1'b0);
        wait_done(2);

        // Abort after 6 bytes with a word still pending
        d0 = done_cnt;
        wr_vld = 1'b0;
        start_sector();
        send_range(2, 0, 5, 1'b0);
        chk("abort_pre_wr_en", 32'(wr_en), 32'd1);
        sec_abort = 1'b1;
        @(posedge clk);
        #1;
        sec_abort = 1'b0;
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_busy", 32'(sec_busy), 32'd0);
        chk("abort_byte_cnt", 32'(byte_cnt), 32'd6);
        wr_vld = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_no_write", 32'(exp_q.size()), 32'd0);

        // Next sector packs from lane 0; a sec_start during RECV is ignored
        push_sector(3);
        start_sector();
        send_range(3, 0, 9, 1'b0);
        sec_start = 1'b1;
        @(posedge clk);
        #1;
        sec_start = 1'b0;
        chk("restart_byte_cnt", 32'(byte_cnt), 32'd10);
        chk("restart_busy", 32'(sec_busy), 32'd1);
        send_range(3, 10, 511, 1'b0);
        wait_done(d0 + 1);

        // sec_start together with sec_abort returns to IDLE
        start_sector();
        send_range(4, 0, 2, 1'b0);
        sec_start = 1'b1;
        sec_abort = 1'b1;
        @(posedge clk);
        #1;
        sec_start = 1'b0;
        sec_abort = 1'b0;
        chk("start_abort_busy", 32'(sec_busy), 32'd0);
        chk("start_abort_rdy", 32'(sec_byte_rdy), 32'd0);
        @(posedge clk);
        #1;
        chk("start_abort_idle", 32'(sec_busy), 32'd0);

        // Reset mid-sector clears byte_cnt
        wr_vld = 1'b0;
        start_sector();
        send_range(5, 0, 4, 1'b0);
        wr_rst = 1'b1;
        @(posedge clk);
        #1;
        wr_rst = 1'b0;
        chk("mid_rst_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", 32'(sec_busy), 32'd0);
        wr_vld = 1'b1;

        // 50 sectors with random byte gaps and random backpressure
        d0 = done_cnt;
        rnd_wr = 1'b1;
        for (int s = 0; s < 50; s++) begin
            push_sector(10 + s);
            start_sector();
            send_range(10 + s, 0, 511, 1'b1);
            wait_done(d0 + s + 1);
        end
        rnd_wr = 1'b0;
        chk("random_done_count", 32'(done_cnt - d0), 32'd50);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_card_fifo_writer.md
# sd_card_fifo_writer

Write-side producer for the SD-card sector FIFO. Accepts the byte stream from the SD-card data receiver one sector at a time, packs bytes into 32-bit words, and drives the FIFO write port (`wr_data`/`wr_en`, backpressured by `wr_vld`). Provides per-sector start/done/abort control so the SD command sequencer can track sector completion. Sits between the SD receive datapath and the prefetch FIFO, in the FIFO's write-clock domain.

## Interface
Parameters:
- `c_SECTOR_BYTES`, 512: bytes per sector; multiple of 4, range 4..4096.
- `c_BIG_ENDIAN`, 0: 0 places the first byte of each word in `wr_data[7:0]`; 1 places it in `wr_data[31:24]`.
- `c_CNT_WIDTH`, 10: width of `byte_cnt`; must satisfy 2^c_CNT_WIDTH > c_SECTOR_BYTES.

Ports:
- `wr_clk` in 1: the only clock; all logic on its rising edge.
- `wr_rst` in 1: reset, synchronous, active-high.
- `sec_start` in 1: one-cycle pulse that begins a sector; ignored unless idle.
- `sec_abort` in 1: discards the current sector immediately.
- `sec_byte` in 8: received data byte.
- `sec_byte_vld` in 1: `sec_byte` is valid.
- `sec_byte_rdy` out 1: the block accepts `sec_byte` this cycle.
- `sec_busy` out 1: a sector is in progress.
- `sec_done` out 1: one-cycle pulse; all words of the sector have been written to the FIFO.
- `byte_cnt` out c_CNT_WIDTH: bytes accepted in the current sector.
- `wr_data` out 32: FIFO write data.
- `wr_en` out 1: FIFO write request.
- `wr_vld` in 1: FIFO not full; a write occurs when `wr_en & wr_vld`.

## Operation
- States: IDLE, RECV, FLUSH.
- IDLE: `sec_byte_rdy`=0, `sec_busy`=0. `sec_start` moves to RECV and clears `byte_cnt`, the lane counter and the pack register.
- RECV: a byte is accepted when `sec_byte_vld & sec_byte_rdy`. Each accepted byte goes into lane `lane_cnt` (0..3) of the pack register, then `lane_cnt` and `byte_cnt` increment. `lane_cnt` wraps 3→0.
- Word completion: when the lane-3 byte is accepted, the complete word is loaded into the output register and `wr_en`=1 from the next cycle.
- Output register: `wr_en`/`wr_data` stay stable until `wr_vld`=1. It is cleared on the write cycle unless a new word is loaded in that same cycle, in which case `wr_en` stays 1 with the new data.
- `sec_byte_rdy` = RECV & (`lane_cnt`≠3 | ~`wr_en` | `wr_vld`). Non-final lanes never stall, so one byte per clock is sustained while the FIFO is not full.
- When byte `c_SECTOR_BYTES` is accepted, the state moves to FLUSH and `sec_byte_rdy` drops to 0.
- FLUSH: waits for the final word's write (`wr_en & wr_vld`). On that cycle the state moves to IDLE, and `sec_done` pulses the following cycle.
- `sec_abort` (any state, highest priority after reset): next cycle the state is IDLE, `wr_en`=0, and the partial pack and pending word are dropped. `sec_done` is not pulsed. `byte_cnt` holds its value for diagnosis.
- A `sec_start` arriving in the same cycle as `sec_abort` is ignored.

## Timing
- Reset values: state IDLE, `wr_en`=0, `wr_data`=0, `sec_byte_rdy`=0, `sec_busy`=0, `sec_done`=0, `byte_cnt`=0.
- `sec_start` at cycle N → `sec_busy`=1 and `sec_byte_rdy`=1 at N+1.
- Lane-3 byte accepted at cycle N → `wr_en`=1 at N+1 (latency 1).
- Last write handshake at cycle M → `sec_busy`=0 at M+1 and `sec_done`=1 at M+1 only.
- With `wr_vld` held at 1, a sector takes `c_SECTOR_BYTES`+2 cycles from `sec_start` to `sec_done`.
- `wr_vld` low while a word is pending and the lane-3 byte is presented → `sec_byte_rdy`=0 that cycle; no byte is lost and no word is overwritten.
- `wr_rst` mid-sector has the same effect as `sec_abort` and also clears `byte_cnt`.

## Test plan
- Reset, then `c_BIG_ENDIAN`=0: `sec_start`, then bytes 0x00..0xFF,0x00..0xFF with `wr_vld`=1 → 128 writes; first `wr_data`=0x03020100, last=0xFFFEFDFC; `sec_done` exactly once, 514 cycles after `sec_start`.
- `c_BIG_ENDIAN`=1, bytes 0x11,0x22,0x33,0x44 → `wr_data`=0x11223344.
- `wr_vld` low for 10 cycles while a word is pending and the next word's lane-3 byte is presented → `sec_byte_rdy`=0 and `wr_data` stable; after release, both words are written in order and none is duplicated.
- `sec_abort` after 6 bytes → `wr_en`=0 next cycle, no `sec_done`, `byte_cnt`=6; a following sector packs from lane 0.
- `sec_start` pulsed during RECV → ignored, `byte_cnt` unaffected; `sec_start` together with `sec_abort` → block returns to IDLE.
- Random `sec_byte_vld` and random `wr_vld` over 50 sectors → scoreboard matches all 128 words per sector, and `sec_done` count = 50.
